cru_bits_sync: RTL and testbench

- Sits directly downstream of the 4-bit CRU register block. Its input bits change on the TI CRU clock and are asynchronous to the local system clock.
- Brings those bits into the system clock domain, glitch-filters each one and produces one-cycle edge strobes.
- Bit 0 drives the DSR enable level. Bit 1 triggers a fixed-width, level-re-armed reset pulse to the Raspberry Pi. Bits 2 and 3 pass on as filtered levels.

---
 rtl/cru_bits_sync_if.sv | 22 ++
 rtl/cru_bits_sync.sv | 132 +++++++++++++
 tb/tb_cru_bits_sync.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cru_bits_sync_if.sv
// Signal bundle between the CRU bit register block and cru_bits_sync.
// The master side drives the raw CRU bits and observes the conditioned outputs.
// The slave side is the synchronizer/filter block.
interface cru_bits_sync_if;
    logic [0:3] cru_bits;    // raw CRU register bits, asynchronous to clk
    logic [0:3] bits_f;      // synchronized, glitch-filtered levels
    logic [0:3] rise;        // one-cycle 0->1 strobes of bits_f
    logic [0:3] fall;        // one-cycle 1->0 strobes of bits_f
    logic       dsr_en;      // DSR enable level (bits_f[0])
    logic       pi_reset_n;  // active-low Raspberry Pi reset pulse
    logic       reset_busy;  // reset state machine is not idle

    modport master (
        output cru_bits,
        input  bits_f, rise, fall, dsr_en, pi_reset_n, reset_busy
    );

    modport slave (
        input  cru_bits,
        output bits_f, rise, fall, dsr_en, pi_reset_n, reset_busy
    );
endinterface

// File: rtl/cru_bits_sync.sv
// CRU bit conditioning: the four CRU register bits arrive on the TI CRU clock.
// This block brings them into the clk domain, removes glitches shorter than
// FILTER_CYCLES and produces one-cycle edge strobes for each bit.
// Bit 0 is the DSR enable level. Bit 1 fires a fixed-width Raspberry Pi reset
// pulse. That pulse re-arms only after the bit has been cleared again.
// Bits 2 and 3 are passed on as filtered levels.
module cru_bits_sync #(
    parameter int SYNC_STAGES   = 2,    // 2..4
    parameter int FILTER_CYCLES = 4,    // 1..255
    parameter int RESET_CYCLES  = 1000  // 1..65535
) (
    input  logic           clk,
    input  logic           rst_n,
    cru_bits_sync_if.slave bus
);

    localparam logic [7:0]  FC_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [15:0] PC_LOAD = 16'(RESET_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,   // waiting for a rise on bit 1
        ST_PULSE,  // pi_reset_n held low for RESET_CYCLES clocks
        ST_REARM   // pulse done; waiting for bit 1 to be cleared
    } state_t;

    logic [0:3]  sync_q [SYNC_STAGES];
    logic [0:3]  s;
    logic [7:0]  fc [4];
    logic [0:3]  bits_f_q;
    logic [0:3]  rise_q;
    logic [0:3]  fall_q;
    state_t      state;
    logic [15:0] pc;
    logic        pi_reset_n_q;
    logic        reset_busy_q;

    // Synchronizer chains: plain flop-to-flop, no logic between stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value, so the chain really is SYNC_STAGES deep.
            sync_q[0] <= bus.cru_bits;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Per-bit glitch filter: flip only after FILTER_CYCLES consecutive disagreeing clocks; strobe on the flip.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits_f_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                fc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (s[i] == bits_f_q[i]) begin
                    fc[i] <= '0;
                end else if (fc[i] == FC_LAST) begin
                    // The strobe is registered on the same edge as the level,
                    // so it lines up with the first cycle of the new value.
                    bits_f_q[i] <= s[i];
                    fc[i]       <= '0;
                    rise_q[i]   <= s[i];
                    fall_q[i]   <= ~s[i];
                end else begin
                    fc[i] <= fc[i] + 8'd1;
                end
            end
        end
    end

    // Pi reset sequencer: one fixed-width pulse per rise of bit 1.
    // The bit must then return low before the next pulse can fire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            pc           <= '0;
            pi_reset_n_q <= 1'b1;
            reset_busy_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise_q[1]) begin
                        state        <= ST_PULSE;
                        pc           <= PC_LOAD;
                        pi_reset_n_q <= 1'b0;
                        reset_busy_q <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    // The pulse always runs to full width. Neither a fall nor
                    // another rise on bit 1 shortens or extends it.
                    pc <= pc - 16'd1;
                    if (pc == 16'd1) begin
                        state        <= ST_REARM;
                        pi_reset_n_q <= 1'b1;
                    end
                end
                ST_REARM: begin
                    if (!bits_f_q[1]) begin
                        state        <= ST_IDLE;
                        reset_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    pi_reset_n_q <= 1'b1;
                    reset_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bits_f     = bits_f_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.dsr_en     = bits_f_q[0];
    assign bus.pi_reset_n = pi_reset_n_q;
    assign bus.reset_busy = reset_busy_q;

endmodule

// File: tb/tb_cru_bits_sync.sv
// Bench for cru_bits_sync. Expected edge strobes and Pi reset pulses are queued
// when the stimulus is driven. A negedge monitor pops and compares them when
// the DUT produces them. Directed level checks sit inline in the sequence.
module tb_cru_bits_sync;

    localparam int SYNC_STAGES   = 2;
    localparam int FILTER_CYCLES = 4;
    localparam int RESET_CYCLES  = 8;
    localparam int LAT           = SYNC_STAGES + FILTER_CYCLES;

    typedef struct {
        int bit_idx;
        bit is_rise;
        int cyc;
    } strobe_t;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   t;
    int   t2;

    strobe_t exp_strobes[$];
    pulse_t  exp_pulses[$];

    cru_bits_sync_if bus ();

    cru_bits_sync #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strobe(input int b, input bit r, input int c);
        exp_strobes.push_back('{bit_idx: b, is_rise: r, cyc: c});
    endtask

    task automatic expect_pulse(input int start, input int width);
        exp_pulses.push_back('{start: start, width: width});
    endtask

    // Held-high bit 1 from idle: one full pulse, then REARM until the bit is cleared.
    task automatic pi_pulse_held(input string tag);
        int ts;
        ts = cyc;
        bus.cru_bits[1] = 1'b1;
        expect_strobe(1, 1'b1, ts + LAT);
        expect_pulse(ts + LAT + 1, RESET_CYCLES);
        step(LAT);
        check({tag, "_pre_pi"}, 32'(bus.pi_reset_n), 1);
        check({tag, "_pre_busy"}, 32'(bus.reset_busy), 0);
        step(1);
        check({tag, "_first_low"}, 32'(bus.pi_reset_n), 0);
        check({tag, "_busy"}, 32'(bus.reset_busy), 1);
        step(RESET_CYCLES - 1);
        check({tag, "_last_low"}, 32'(bus.pi_reset_n), 0);
        step(1);
        check({tag, "_released"}, 32'(bus.pi_reset_n), 1);
        check({tag, "_rearm_busy"}, 32'(bus.reset_busy), 1);
        step(20);
        check({tag, "_held_pi"}, 32'(bus.pi_reset_n), 1);
        check({tag, "_held_busy"}, 32'(bus.reset_busy), 1);
        ts = cyc;
        bus.cru_bits[1] = 1'b0;
        expect_strobe(1, 1'b0, ts + LAT);
        step(LAT);
        check({tag, "_clr_busy"}, 32'(bus.reset_busy), 1);
        step(1);
        check({tag, "_idle_busy"}, 32'(bus.reset_busy), 0);
        step(3);
    endtask

    // Monitor: every strobe and every completed pi_reset_n low pulse must match the queue head.
    logic    prev_pi = 1'b1;
    int      pulse_start = 0;
    initial begin
        strobe_t es;
        pulse_t  ep;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("rise_fall_excl_b%0d", i), 32'(bus.rise[i] & bus.fall[i]), 0);
                if (bus.rise[i] || bus.fall[i]) begin
                    check($sformatf("strobe_expected_b%0d_c%0d", i, cyc), 32'(exp_strobes.size() != 0), 1);
                    if (exp_strobes.size() != 0) begin
                        es = exp_strobes.pop_front();
                        check("strobe_bit", 32'(i), 32'(es.bit_idx));
                        check($sformatf("strobe_dir_b%0d", i), 32'(bus.rise[i]), 32'(es.is_rise));
                        check($sformatf("strobe_cycle_b%0d", i), 32'(cyc), 32'(es.cyc));
                    end
                end
            end
            if (prev_pi === 1'b1 && bus.pi_reset_n === 1'b0) pulse_start = cyc;
            if (prev_pi === 1'b0 && bus.pi_reset_n === 1'b1) begin
                check($sformatf("pulse_expected_c%0d", cyc), 32'(exp_pulses.size() != 0), 1);
                if (exp_pulses.size() != 0) begin
                    ep = exp_pulses.pop_front();
                    check("pulse_start", 32'(pulse_start), 32'(ep.start));
                    check("pulse_width", 32'(cyc - pulse_start), 32'(ep.width));
                end
            end
            prev_pi = bus.pi_reset_n;
        end
    end

    initial begin
        // Reset with all bits high.
        rst_n = 1'b0;
        bus.cru_bits = 4'b1111;
        step(3);
        check("rst_bits_f", 32'(bus.bits_f), 0);
        check("rst_rise", 32'(bus.rise), 0);
        check("rst_fall", 32'(bus.fall), 0);
        check("rst_dsr_en", 32'(bus.dsr_en), 0);
        check("rst_pi_reset_n", 32'(bus.pi_reset_n), 1);
        check("rst_reset_busy", 32'(bus.reset_busy), 0);

        // Release: all four bits rise together after the full latency, and bit 1 fires a pulse.
        t = cyc;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) expect_strobe(i, 1'b1, t + LAT);
        expect_pulse(t + LAT + 1, RESET_CYCLES);
        step(LAT - 1);
        check("rel_bits_f_early", 32'(bus.bits_f), 0);
        step(1);
        check("rel_bits_f", 32'(bus.bits_f), 32'b1111);
        check("rel_rise", 32'(bus.rise), 32'b1111);
        check("rel_dsr_en", 32'(bus.dsr_en), 1);
        step(1);
        check("rel_rise_gone", 32'(bus.rise), 0);
        check("rel_pi_low", 32'(bus.pi_reset_n), 0);
        step(RESET_CYCLES);
        check("rel_pi_high", 32'(bus.pi_reset_n), 1);
        check("rel_rearm_busy", 32'(bus.reset_busy), 1);
        step(20);
        check("rel_no_second_pulse", 32'(bus.pi_reset_n), 1);

        // Clear every bit at once.
        t = cyc;
        bus.cru_bits = 4'b0000;
        for (int i = 0; i < 4; i++) expect_strobe(i, 1'b0, t + LAT);
        step(LAT);
        check("clr_bits_f", 32'(bus.bits_f), 0);
        check("clr_dsr_en", 32'(bus.dsr_en), 0);
        check("clr_busy_still", 32'(bus.reset_busy), 1);
        step(1);
        check("clr_busy_idle", 32'(bus.reset_busy), 0);
        step(2);

        // Glitch reject: 3-clock high on bit 2 is swallowed.
        bus.cru_bits[2] = 1'b1;
        step(3);
        bus.cru_bits[2] = 1'b0;
        step(12);
        check("glitch_hi_rejected", 32'(bus.bits_f), 0);

        // Stable high on bit 2 is accepted after the full latency.
        t = cyc;
        bus.cru_bits[2] = 1'b1;
        expect_strobe(2, 1'b1, t + LAT);
        step(LAT - 1);
        check("b2_before", 32'(bus.bits_f), 0);
        step(1);
        check("b2_set", 32'(bus.bits_f), 32'b0010);
        step(4);

        // 3-clock low glitch on a filtered-high bit is swallowed too.
        bus.cru_bits[2] = 1'b0;
        step(3);
        bus.cru_bits[2] = 1'b1;
        step(12);
        check("glitch_lo_rejected", 32'(bus.bits_f), 32'b0010);
        t = cyc;
        bus.cru_bits[2] = 1'b0;
        expect_strobe(2, 1'b0, t + LAT);
        step(LAT + 2);
        check("b2_cleared", 32'(bus.bits_f), 0);

        // DSR level follows bit 0 with the full latency both ways.
        t = cyc;
        bus.cru_bits[0] = 1'b1;
        expect_strobe(0, 1'b1, t + LAT);
        step(LAT - 1);
        check("dsr_up_early", 32'(bus.dsr_en), 0);
        step(1);
        check("dsr_up", 32'(bus.dsr_en), 1);
        step(4);
        t = cyc;
        bus.cru_bits[0] = 1'b0;
        expect_strobe(0, 1'b0, t + LAT);
        step(LAT - 1);
        check("dsr_down_early", 32'(bus.dsr_en), 1);
        step(1);
        check("dsr_down", 32'(bus.dsr_en), 0);
        step(3);

        // Pi reset from idle, then re-arm and fire an identical second pulse.
        pi_pulse_held("pi1");
        pi_pulse_held("pi2");

        // Clear bit 1 two cycles into the pulse: full width, then REARM for one cycle.
        t = cyc;
        bus.cru_bits[1] = 1'b1;
        expect_strobe(1, 1'b1, t + LAT);
        expect_pulse(t + LAT + 1, RESET_CYCLES);
        step(LAT + 2);
        t2 = cyc;
        bus.cru_bits[1] = 1'b0;
        expect_strobe(1, 1'b0, t2 + LAT);
        step(LAT);
        check("early_clr_still_low", 32'(bus.pi_reset_n), 0);
        step(1);
        check("early_clr_pi_high", 32'(bus.pi_reset_n), 1);
        check("early_clr_rearm", 32'(bus.reset_busy), 1);
        step(1);
        check("early_clr_idle", 32'(bus.reset_busy), 0);
        step(3);

        // Reset in the third pulse cycle with bit 1 held: pulse cut, then a fresh full pulse.
        t = cyc;
        bus.cru_bits[1] = 1'b1;
        expect_strobe(1, 1'b1, t + LAT);
        expect_pulse(t + LAT + 1, 3);
        step(LAT + 1);
        check("mid_pulse_low", 32'(bus.pi_reset_n), 0);
        step(2);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_pi", 32'(bus.pi_reset_n), 1);
        check("mid_rst_busy", 32'(bus.reset_busy), 0);
        check("mid_rst_bits_f", 32'(bus.bits_f), 0);
        t2 = cyc;
        rst_n = 1'b1;
        expect_strobe(1, 1'b1, t2 + LAT);
        expect_pulse(t2 + LAT + 1, RESET_CYCLES);
        step(LAT);
        check("mid_rel_bits_f", 32'(bus.bits_f), 32'b0100);
        check("mid_rel_pi_not_yet", 32'(bus.pi_reset_n), 1);
        step(1);
        check("mid_rel_pi_low", 32'(bus.pi_reset_n), 0);
        step(RESET_CYCLES);
        check("mid_rel_pi_high", 32'(bus.pi_reset_n), 1);
        t = cyc;
        bus.cru_bits[1] = 1'b0;
        expect_strobe(1, 1'b0, t + LAT);
        step(LAT + 1);
        check("mid_final_idle", 32'(bus.reset_busy), 0);
        step(5);

        // Everything queued must have been produced.
        check("strobes_left", 32'(exp_strobes.size()), 0);
        check("pulses_left", 32'(exp_pulses.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
